ls_reservation_station: RTL and testbench

In-order reservation station that feeds the load/store unit. It accepts dispatched LD/SD micro-ops from decode and holds them in a circular queue. It snoops the common data bus (CDB) for missing source operands. It issues the oldest entry to the LS unit once all of that entry's operands are ready, honouring the LS unit's stop backpressure. It is the sending end of the RS→LS interface (valid_in, opcode_rs2ls … imm_rs2ls, stop_ls2rsls).

---
 rtl/ls_reservation_station.sv | 140 ++++++++++++++
 tb/tb_ls_reservation_station.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_reservation_station.sv
// In-order reservation station in front of the load/store unit: queues LD/SD ops,
// snoops the CDB for missing operands and issues the oldest entry once it is ready.
module ls_reservation_station #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             valid_dec,
    input  logic [6:0]       opcode_dec,
    input  logic [5:0]       tag_dec,
    input  logic [5:0]       rd_dec,
    input  logic [11:0]      imm_dec,
    input  logic             rs1_rdy_dec,
    input  logic [63:0]      rs1_val_dec,
    input  logic [5:0]       rs1_tag_dec,
    input  logic             rs2_rdy_dec,
    input  logic [63:0]      rs2_val_dec,
    input  logic [5:0]       rs2_tag_dec,
    output logic             stop_rsls2dec,
    input  logic             valid_cdb,
    input  logic [5:0]       tag_cdb,
    input  logic [63:0]      value_cdb,
    output logic             valid_in,
    output logic [6:0]       opcode_rs2ls,
    output logic [5:0]       tag_rs2ls,
    output logic [63:0]      rs1_rs2ls,
    output logic [63:0]      rs2_rs2ls,
    output logic [5:0]       rd_rs2ls,
    output logic [11:0]      imm_rs2ls,
    input  logic             stop_ls2rsls,
    output logic [PTR_W:0]   count_o
);

    localparam logic [6:0] OP_LD = 7'b0000011;

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [5:0]  tag;
        logic [5:0]  rd;
        logic [11:0] imm;
        logic        rdy1;
        logic [63:0] val1;
        logic [5:0]  tag1;
        logic        rdy2;
        logic [63:0] val2;
        logic [5:0]  tag2;
    } entry_t;

    entry_t             q [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     count;
    entry_t             head_e;
    entry_t             new_e;
    logic               do_dispatch;
    logic               do_issue;

    assign head_e        = q[head];
    assign count_o       = count;
    assign stop_rsls2dec = (count == (PTR_W+1)'(DEPTH));
    assign valid_in      = head_e.valid & head_e.rdy1 & head_e.rdy2;
    assign do_dispatch   = valid_dec & ~stop_rsls2dec;
    assign do_issue      = valid_in & ~stop_ls2rsls;

    // Slots left behind by an issue keep stale data, so gate the outputs on head valid.
    assign opcode_rs2ls = head_e.valid ? head_e.opcode : '0;
    assign tag_rs2ls    = head_e.valid ? head_e.tag    : '0;
    assign rs1_rs2ls    = head_e.valid ? head_e.val1   : '0;
    assign rs2_rs2ls    = head_e.valid ? head_e.val2   : '0;
    assign rd_rs2ls     = head_e.valid ? head_e.rd     : '0;
    assign imm_rs2ls    = head_e.valid ? head_e.imm    : '0;

    // Incoming entry, with same-cycle CDB forwarding and LD's rs2 forced ready.
    always_comb begin
        // NOTE: every field gets a default first so no latch can be inferred.
        new_e        = '0;
        new_e.valid  = 1'b1;
        new_e.opcode = opcode_dec;
        new_e.tag    = tag_dec;
        new_e.rd     = rd_dec;
        new_e.imm    = imm_dec;
        new_e.rdy1   = rs1_rdy_dec;
        new_e.val1   = rs1_val_dec;
        new_e.tag1   = rs1_tag_dec;
        new_e.rdy2   = rs2_rdy_dec;
        new_e.val2   = rs2_val_dec;
        new_e.tag2   = rs2_tag_dec;
        if (valid_cdb && !rs1_rdy_dec && rs1_tag_dec == tag_cdb) begin
            new_e.rdy1 = 1'b1;
            new_e.val1 = value_cdb;
        end
        if (opcode_dec == OP_LD) begin
            new_e.rdy2 = 1'b1;
            new_e.val2 = '0;
        end else if (valid_cdb && !rs2_rdy_dec && rs2_tag_dec == tag_cdb) begin
            new_e.rdy2 = 1'b1;
            new_e.val2 = value_cdb;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            // NOTE: the entry array is fully reset; it is tiny and this keeps outputs clean from reset.
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: non-blocking throughout; later writes to the same entry below take priority.
            if (valid_cdb) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q[i].valid && !q[i].rdy1 && q[i].tag1 == tag_cdb) begin
                        q[i].rdy1 <= 1'b1;
                        q[i].val1 <= value_cdb;
                    end
                    if (q[i].valid && !q[i].rdy2 && q[i].tag2 == tag_cdb) begin
                        q[i].rdy2 <= 1'b1;
                        q[i].val2 <= value_cdb;
                    end
                end
            end
            if (do_issue) begin
                q[head].valid <= 1'b0;
                head          <= head + 1'b1;
            end
            if (do_dispatch) begin
                q[tail] <= new_e;
                tail    <= tail + 1'b1;
            end
            case ({do_dispatch, do_issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_reservation_station.sv
// Directed bench for ls_reservation_station: one task per scenario, inline checks.
module tb_ls_reservation_station;

    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    logic        clk = 1'b0;
    logic        res_n;
    logic        valid_dec;
    logic [6:0]  opcode_dec;
    logic [5:0]  tag_dec;
    logic [5:0]  rd_dec;
    logic [11:0] imm_dec;
    logic        rs1_rdy_dec;
    logic [63:0] rs1_val_dec;
    logic [5:0]  rs1_tag_dec;
    logic        rs2_rdy_dec;
    logic [63:0] rs2_val_dec;
    logic [5:0]  rs2_tag_dec;
    logic        stop_rsls2dec;
    logic        valid_cdb;
    logic [5:0]  tag_cdb;
    logic [63:0] value_cdb;
    logic        valid_in;
    logic [6:0]  opcode_rs2ls;
    logic [5:0]  tag_rs2ls;
    logic [63:0] rs1_rs2ls;
    logic [63:0] rs2_rs2ls;
    logic [5:0]  rd_rs2ls;
    logic [11:0] imm_rs2ls;
    logic        stop_ls2rsls;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    ls_reservation_station #(.DEPTH(4)) dut (
        .clk(clk), .res_n(res_n),
        .valid_dec(valid_dec), .opcode_dec(opcode_dec), .tag_dec(tag_dec),
        .rd_dec(rd_dec), .imm_dec(imm_dec),
        .rs1_rdy_dec(rs1_rdy_dec), .rs1_val_dec(rs1_val_dec), .rs1_tag_dec(rs1_tag_dec),
        .rs2_rdy_dec(rs2_rdy_dec), .rs2_val_dec(rs2_val_dec), .rs2_tag_dec(rs2_tag_dec),
        .stop_rsls2dec(stop_rsls2dec),
        .valid_cdb(valid_cdb), .tag_cdb(tag_cdb), .value_cdb(value_cdb),
        .valid_in(valid_in), .opcode_rs2ls(opcode_rs2ls), .tag_rs2ls(tag_rs2ls),
        .rs1_rs2ls(rs1_rs2ls), .rs2_rs2ls(rs2_rs2ls), .rd_rs2ls(rd_rs2ls),
        .imm_rs2ls(imm_rs2ls), .stop_ls2rsls(stop_ls2rsls), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [6:0] op, input logic [5:0] tag, input logic [11:0] imm,
                          input logic r1rdy, input logic [63:0] r1val, input logic [5:0] r1tag,
                          input logic r2rdy, input logic [63:0] r2val, input logic [5:0] r2tag);
        valid_dec   = 1'b1;
        opcode_dec  = op;
        tag_dec     = tag;
        rd_dec      = tag ^ 6'h3f;
        imm_dec     = imm;
        rs1_rdy_dec = r1rdy;
        rs1_val_dec = r1val;
        rs1_tag_dec = r1tag;
        rs2_rdy_dec = r2rdy;
        rs2_val_dec = r2val;
        rs2_tag_dec = r2tag;
    endtask

    task automatic test_reset();
        total++;
        if ({valid_in, stop_rsls2dec, count_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: valid_in=%b stop=%b count=%0d, want 0 0 0", valid_in, stop_rsls2dec, count_o);
        end
        total++;
        if ({opcode_rs2ls, tag_rs2ls, rs1_rs2ls, rs2_rs2ls, rd_rs2ls, imm_rs2ls} !== '0) begin
            bad++;
            $display("FAIL reset_data: tag=%0d rs1=%h rs2=%h imm=%h, want all 0", tag_rs2ls, rs1_rs2ls, rs2_rs2ls, imm_rs2ls);
        end
    endtask

    task automatic test_ready_dispatch();
        set_op(OP_SD, 6'd5, 12'd8, 1'b1, 64'h10, 6'd0, 1'b1, 64'hAB, 6'd0);
        tick();
        valid_dec = 1'b0;
        total++;
        if ({valid_in, opcode_rs2ls, tag_rs2ls, rd_rs2ls, imm_rs2ls} !== {1'b1, OP_SD, 6'd5, 6'd58, 12'd8}) begin
            bad++;
            $display("FAIL ready_ctrl: valid=%b op=%b tag=%0d rd=%0d imm=%0d, want 1 0100011 5 58 8",
                     valid_in, opcode_rs2ls, tag_rs2ls, rd_rs2ls, imm_rs2ls);
        end
        total++;
        if (rs1_rs2ls !== 64'h10 || rs2_rs2ls !== 64'hAB) begin
            bad++;
            $display("FAIL ready_vals: rs1=%h rs2=%h, want 10 ab", rs1_rs2ls, rs2_rs2ls);
        end
        tick();
        total++;
        if (count_o !== 3'd0 || valid_in !== 1'b0) begin
            bad++;
            $display("FAIL ready_drain: count=%0d valid=%b, want 0 0", count_o, valid_in);
        end
    endtask

    task automatic test_cdb_wakeup();
        // rs2 deliberately "waiting" on the same tag: LD must ignore it and keep rs2 = 0
        set_op(OP_LD, 6'd20, 12'd4, 1'b0, 64'hDEAD, 6'd12, 1'b0, 64'hBEEF, 6'd12);
        tick();
        valid_dec = 1'b0;
        total++;
        if (valid_in !== 1'b0 || count_o !== 3'd1) begin
            bad++;
            $display("FAIL wake_wait: valid=%b count=%0d, want 0 1", valid_in, count_o);
        end
        valid_cdb = 1'b1; tag_cdb = 6'd12; value_cdb = 64'h1234;
        tick();
        valid_cdb = 1'b0;
        total++;
        if ({valid_in, tag_rs2ls} !== {1'b1, 6'd20} || rs1_rs2ls !== 64'h1234 || rs2_rs2ls !== 64'h0) begin
            bad++;
            $display("FAIL wake_issue: valid=%b tag=%0d rs1=%h rs2=%h, want 1 20 1234 0",
                     valid_in, tag_rs2ls, rs1_rs2ls, rs2_rs2ls);
        end
        tick();
    endtask

    task automatic test_cdb_forward();
        set_op(OP_LD, 6'd21, 12'd4, 1'b0, 64'hDEAD, 6'd12, 1'b0, 64'hBEEF, 6'd12);
        valid_cdb = 1'b1; tag_cdb = 6'd12; value_cdb = 64'h1234;
        tick();
        valid_dec = 1'b0; valid_cdb = 1'b0;
        total++;
        if ({valid_in, tag_rs2ls} !== {1'b1, 6'd21} || rs1_rs2ls !== 64'h1234 || rs2_rs2ls !== 64'h0) begin
            bad++;
            $display("FAIL fwd_ld: valid=%b tag=%0d rs1=%h rs2=%h, want 1 21 1234 0",
                     valid_in, tag_rs2ls, rs1_rs2ls, rs2_rs2ls);
        end
        tick();
        // SD with both sources on tag 9: one broadcast wakes both
        set_op(OP_SD, 6'd22, 12'd0, 1'b0, 64'h0, 6'd9, 1'b0, 64'h0, 6'd9);
        tick();
        valid_dec = 1'b0;
        valid_cdb = 1'b1; tag_cdb = 6'd9; value_cdb = 64'h55;
        tick();
        valid_cdb = 1'b0;
        total++;
        if (valid_in !== 1'b1 || rs1_rs2ls !== 64'h55 || rs2_rs2ls !== 64'h55) begin
            bad++;
            $display("FAIL wake_both: valid=%b rs1=%h rs2=%h, want 1 55 55", valid_in, rs1_rs2ls, rs2_rs2ls);
        end
        tick();
    endtask

    task automatic test_in_order();
        set_op(OP_SD, 6'd30, 12'd0, 1'b0, 64'h0, 6'd7, 1'b1, 64'h1, 6'd0);
        tick();
        set_op(OP_SD, 6'd31, 12'd0, 1'b1, 64'h2, 6'd0, 1'b1, 64'h3, 6'd0);
        tick();
        valid_dec = 1'b0;
        tick();
        tick();
        total++;
        if (valid_in !== 1'b0 || count_o !== 3'd2) begin
            bad++;
            $display("FAIL order_block: valid=%b count=%0d, want 0 2", valid_in, count_o);
        end
        valid_cdb = 1'b1; tag_cdb = 6'd7; value_cdb = 64'h77;
        tick();
        valid_cdb = 1'b0;
        total++;
        if (valid_in !== 1'b1 || tag_rs2ls !== 6'd30 || rs1_rs2ls !== 64'h77) begin
            bad++;
            $display("FAIL order_first: valid=%b tag=%0d rs1=%h, want 1 30 77", valid_in, tag_rs2ls, rs1_rs2ls);
        end
        tick();
        total++;
        if (valid_in !== 1'b1 || tag_rs2ls !== 6'd31 || rs1_rs2ls !== 64'h2) begin
            bad++;
            $display("FAIL order_second: valid=%b tag=%0d rs1=%h, want 1 31 2", valid_in, tag_rs2ls, rs1_rs2ls);
        end
        tick();
        total++;
        if (count_o !== 3'd0) begin
            bad++;
            $display("FAIL order_drain: count=%0d, want 0", count_o);
        end
    endtask

    task automatic test_back_pressure();
        int unstable = 0;
        stop_ls2rsls = 1'b1;
        set_op(OP_SD, 6'd40, 12'h7FF, 1'b1, 64'hDEAD, 6'd0, 1'b1, 64'hBEEF, 6'd0);
        tick();
        valid_dec = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (valid_in !== 1'b1 || tag_rs2ls !== 6'd40 || rs1_rs2ls !== 64'hDEAD ||
                rs2_rs2ls !== 64'hBEEF || imm_rs2ls !== 12'h7FF || count_o !== 3'd1)
                unstable++;
            tick();
        end
        total++;
        if (unstable !== 0) begin
            bad++;
            $display("FAIL bp_hold: unstable_cycles=%0d, want 0", unstable);
        end
        stop_ls2rsls = 1'b0;
        tick();
        total++;
        if (count_o !== 3'd0 || valid_in !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: count=%0d valid=%b, want 0 0", count_o, valid_in);
        end
    endtask

    task automatic test_full_wrap();
        logic [5:0] exp_tags [12];
        int k = 0;
        int sent = 0;
        for (int i = 0; i < 4; i++) exp_tags[i] = 6'd50 + 6'(i);
        for (int i = 0; i < 8; i++) exp_tags[4+i] = 6'd60 + 6'(i);
        stop_ls2rsls = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(OP_SD, 6'd50 + 6'(i), 12'(i), 1'b1, 64'(i), 6'd0, 1'b1, 64'(i), 6'd0);
            tick();
        end
        valid_dec = 1'b0;
        total++;
        if (stop_rsls2dec !== 1'b1 || count_o !== 3'd4) begin
            bad++;
            $display("FAIL full_stop: stop=%b count=%0d, want 1 4", stop_rsls2dec, count_o);
        end
        set_op(OP_SD, 6'd54, 12'd0, 1'b1, 64'h0, 6'd0, 1'b1, 64'h0, 6'd0);
        tick();
        valid_dec = 1'b0;
        total++;
        if (count_o !== 3'd4 || tag_rs2ls !== 6'd50) begin
            bad++;
            $display("FAIL full_drop: count=%0d head_tag=%0d, want 4 50", count_o, tag_rs2ls);
        end
        stop_ls2rsls = 1'b0;
        for (int cyc = 0; cyc < 40 && k < 12; cyc++) begin
            if (sent < 8 && !stop_rsls2dec) begin
                set_op(OP_SD, 6'd60 + 6'(sent), 12'(sent), 1'b1, 64'(sent), 6'd0, 1'b1, 64'(sent), 6'd0);
                sent++;
            end else begin
                valid_dec = 1'b0;
            end
            if (valid_in) begin
                total++;
                if (tag_rs2ls !== exp_tags[k]) begin
                    bad++;
                    $display("FAIL wrap_order: issue #%0d tag=%0d, want %0d", k, tag_rs2ls, exp_tags[k]);
                end
                k++;
            end
            tick();
        end
        valid_dec = 1'b0;
        total++;
        if (k !== 12 || count_o !== 3'd0) begin
            bad++;
            $display("FAIL wrap_total: issued=%0d count=%0d, want 12 0", k, count_o);
        end
    endtask

    task automatic test_reset_mid();
        stop_ls2rsls = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(OP_SD, 6'd1 + 6'(i), 12'd1, 1'b1, 64'h99, 6'd0, 1'b1, 64'h98, 6'd0);
            tick();
        end
        valid_dec = 1'b0;
        total++;
        if (count_o !== 3'd3 || valid_in !== 1'b1) begin
            bad++;
            $display("FAIL mid_fill: count=%0d valid=%b, want 3 1", count_o, valid_in);
        end
        res_n = 1'b0;
        tick();
        test_reset();
        res_n = 1'b1;
        stop_ls2rsls = 1'b0;
        tick();
        total++;
        if (valid_in !== 1'b0 || count_o !== 3'd0) begin
            bad++;
            $display("FAIL mid_discard: valid=%b count=%0d, want 0 0", valid_in, count_o);
        end
    endtask

    initial begin
        res_n = 1'b0;
        valid_dec = 1'b0; opcode_dec = '0; tag_dec = '0; rd_dec = '0; imm_dec = '0;
        rs1_rdy_dec = 1'b0; rs1_val_dec = '0; rs1_tag_dec = '0;
        rs2_rdy_dec = 1'b0; rs2_val_dec = '0; rs2_tag_dec = '0;
        valid_cdb = 1'b0; tag_cdb = '0; value_cdb = '0;
        stop_ls2rsls = 1'b0;
        tick();
        tick();
        res_n = 1'b1;
        tick();
        test_reset();
        test_ready_dispatch();
        test_cdb_wakeup();
        test_cdb_forward();
        test_in_order();
        test_back_pressure();
        test_full_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
